// File: rtl/dmem_map_pkg.sv
// Shared memory map for the data-memory responder.
// Holds the MMIO window base, the per-register offsets inside that window,
// and the bit positions of the fields in the STATUS register.
package dmem_map_pkg;

    // address_dmem[31:16] value that selects the MMIO window
    localparam logic [15:0] MMIO_BASE = 16'hFFFF;

    // Register offsets, taken from address_dmem[7:0]
    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h01;
    localparam logic [7:0] OFF_STATUS = 8'h02;
    localparam logic [7:0] OFF_LEDS   = 8'h03;

    // STATUS register field positions
    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_ERR     = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;  // 4-bit count field, bits [7:4]

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide transmit FIFO backing the TX_DATA register.
// Circular buffer with wrapping read/write pointers and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored, so push+pop on an empty FIFO is a plain push.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   push          - push request, push_data[7:0] is the byte
//   pop           - pop request (ignored when empty)
//   head[7:0]     - head entry, 0 when empty
//   full, empty   - occupancy flags
//   count         - number of stored entries, 0..FIFO_DEPTH
module tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop && !empty;
    // When full, the slot being freed by the pop is the one written
    // (wr_ptr == rd_ptr), and the head is read before this edge.
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? 8'h00 : mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; count/pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Target-side responder for the processor's data-memory port.
// Word-addressed RAM plus an MMIO window holding a free-running cycle
// counter, a transmit FIFO, an LED register and a sticky status register.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   address_dmem[31:0] - word address from the processor
//   data[31:0], wren   - write data and write enable
//   q_dmem[31:0]       - registered read data (1-clock latency)
//   tx_data[7:0]       - head-of-FIFO byte, tx_valid = FIFO non-empty
//   tx_ready           - downstream accepts tx_data this cycle
//   leds[15:0]         - LED register
//   bus_error          - sticky error bit from STATUS
module dmem_responder #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] MMIO_BASE  = dmem_map_pkg::MMIO_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] leds,
    output logic        bus_error
);
    import dmem_map_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [DEPTH];
    logic [ADDR_W-1:0] ram_idx;
    logic [7:0]        offset;
    logic              is_mmio;
    logic              is_ram;

    logic [31:0]       cycle_q;
    logic [15:0]       leds_q;
    logic              err_q;
    logic              ovf_q;

    logic [31:0]       mmio_rdata;
    logic [31:0]       status;
    logic              offset_ok;
    logic              cycle_wr;
    logic              leds_wr;
    logic              status_rd;
    logic              fifo_push;
    logic              err_set;
    logic              ovf_set;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [3:0]        cnt_disp;
    int unsigned       cnt_ext;

    assign ram_idx = address_dmem[ADDR_W-1:0];
    assign offset  = address_dmem[7:0];
    assign is_mmio = (address_dmem[31:16] == MMIO_BASE);
    assign is_ram  = !is_mmio && (address_dmem < 32'(DEPTH));

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data[7:0]),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    // STATUS snapshot with the count field saturating at 15
    always_comb begin
        cnt_ext  = 32'(fifo_count);
        cnt_disp = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
        status                         = '0;
        status[ST_FULL]                = fifo_full;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_ERR]                 = err_q;
        status[ST_OVF]                 = ovf_q;
        status[ST_CNT_LSB +: 4]        = cnt_disp;
    end

    // MMIO decode; there is no read enable, so every cycle is a read
    always_comb begin
        mmio_rdata = '0;
        offset_ok  = 1'b1;
        cycle_wr   = 1'b0;
        leds_wr    = 1'b0;
        status_rd  = 1'b0;
        fifo_push  = 1'b0;
        if (is_mmio) begin
            case (offset)
                OFF_CYCLE: begin
                    mmio_rdata = cycle_q;
                    cycle_wr   = wren;
                end
                OFF_TXDATA: begin
                    fifo_push = wren;
                end
                OFF_STATUS: begin
                    mmio_rdata = status;
                    status_rd  = 1'b1;
                end
                OFF_LEDS: begin
                    mmio_rdata = {16'h0000, leds_q};
                    leds_wr    = wren;
                end
                default: begin
                    offset_ok = 1'b0;
                end
            endcase
        end
    end

    assign err_set = (!is_mmio && !is_ram) || (is_mmio && !offset_ok);
    // Dropped byte: push while full with no accepted pop
    assign ovf_set = fifo_push && fifo_full && !(tx_ready && !fifo_empty);

    always_ff @(posedge clock) begin
        if (wren && is_ram) ram[ram_idx] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem  <= '0;
            cycle_q <= '0;
            leds_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            q_dmem  <= is_ram ? ram[ram_idx] : mmio_rdata;
            cycle_q <= cycle_wr ? data : cycle_q + 32'd1;
            if (leds_wr) leds_q <= data[15:0];
            // A new event in the same cycle as a STATUS read wins over the clear
            err_q   <= (err_q && !status_rd) || err_set;
            ovf_q   <= (ovf_q && !status_rd) || ovf_set;
        end
    end

    assign leds      = leds_q;
    assign bus_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] leds;
    logic        bus_error;

    int passed;
    int total;

    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_0001;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0002;
    localparam logic [31:0] A_LEDS   = 32'hFFFF_0003;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .leds         (leds),
        .bus_error    (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; outputs are sampled and inputs changed 1ns later
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        address_dmem = A_TXDATA;
        data         = {24'h0, b};
        wren         = 1'b1;
        step();
        wren         = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (q_dmem !== 32'h0) $display("FAIL reset_q: got %h want %h", q_dmem, 32'h0); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL reset_txvalid: got %b want 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_txdata: got %h want 00", tx_data); else passed++;
        total++; if (leds !== 16'h0) $display("FAIL reset_leds: got %h want 0000", leds); else passed++;
        total++; if (bus_error !== 1'b0) $display("FAIL reset_buserr: got %b want 0", bus_error); else passed++;
        reset        = 1'b0;
        address_dmem = A_STATUS;
        step();
        total++; if (q_dmem !== 32'h02) $display("FAIL reset_status: got %h want %h", q_dmem, 32'h02); else passed++;
    endtask

    task automatic test_counter();
        reset        = 1'b1;
        address_dmem = 32'h0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        address_dmem = A_CYCLE;
        step();
        total++; if (q_dmem !== 32'd10) $display("FAIL cycle_10: got %h want %h", q_dmem, 32'd10); else passed++;
        data = 32'hFFFF_FFFE;
        wren = 1'b1;
        step();
        wren = 1'b0;
        address_dmem = A_CYCLE;
        step();
        total++; if (q_dmem !== 32'hFFFF_FFFE) $display("FAIL cycle_load: got %h want %h", q_dmem, 32'hFFFF_FFFE); else passed++;
        step();
        total++; if (q_dmem !== 32'hFFFF_FFFF) $display("FAIL cycle_max: got %h want %h", q_dmem, 32'hFFFF_FFFF); else passed++;
        step();
        total++; if (q_dmem !== 32'h0) $display("FAIL cycle_wrap: got %h want %h", q_dmem, 32'h0); else passed++;
    endtask

    task automatic test_ram();
        address_dmem = 32'd5;
        data         = 32'hDEAD_BEEF;
        wren         = 1'b1;
        step();
        address_dmem = 32'd6;
        data         = 32'h0;
        step();
        wren         = 1'b0;
        address_dmem = 32'd5;
        step();
        total++; if (q_dmem !== 32'hDEAD_BEEF) $display("FAIL ram_rd5: got %h want %h", q_dmem, 32'hDEAD_BEEF); else passed++;
        address_dmem = 32'd6;
        step();
        total++; if (q_dmem !== 32'h0) $display("FAIL ram_rd6: got %h want %h", q_dmem, 32'h0); else passed++;
        // Read-during-write returns the old word
        address_dmem = 32'd5;
        data         = 32'h1234_5678;
        wren         = 1'b1;
        step();
        wren = 1'b0;
        total++; if (q_dmem !== 32'hDEAD_BEEF) $display("FAIL ram_rdw_old: got %h want %h", q_dmem, 32'hDEAD_BEEF); else passed++;
        step();
        total++; if (q_dmem !== 32'h1234_5678) $display("FAIL ram_rdw_new: got %h want %h", q_dmem, 32'h1234_5678); else passed++;
    endtask

    task automatic test_fifo_basic();
        tx_ready = 1'b0;
        push_byte(8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        address_dmem = A_STATUS;
        step();
        total++; if (q_dmem !== 32'h30) $display("FAIL fifo_status3: got %h want %h", q_dmem, 32'h30); else passed++;
        total++; if (tx_data !== 8'h41 || tx_valid !== 1'b1)
            $display("FAIL fifo_head_hold: got %h/%b want 41/1", tx_data, tx_valid); else passed++;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i))
                $display("FAIL fifo_pop%0d: got %h/%b want %h/1", i, tx_data, tx_valid, 8'(8'h41 + i));
            else passed++;
            step();
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) $display("FAIL fifo_drained: got %b want 0", tx_valid); else passed++;
        step();
        total++; if (q_dmem !== 32'h02) $display("FAIL fifo_status_empty: got %h want %h", q_dmem, 32'h02); else passed++;
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i));
        address_dmem = A_STATUS;
        step();
        total++; if (q_dmem !== 32'h89) $display("FAIL ovf_status: got %h want %h", q_dmem, 32'h89); else passed++;
        step();
        total++; if (q_dmem !== 32'h81) $display("FAIL ovf_cleared: got %h want %h", q_dmem, 32'h81); else passed++;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_bytes [8];
        for (int i = 0; i < 7; i++) exp_bytes[i] = 8'(8'h11 + i);
        exp_bytes[7] = 8'h55;
        tx_ready = 1'b1;
        push_byte(8'h55);
        tx_ready     = 1'b0;
        address_dmem = A_STATUS;
        step();
        total++; if (q_dmem !== 32'h81) $display("FAIL fullpop_status: got %h want %h", q_dmem, 32'h81); else passed++;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i])
                $display("FAIL fullpop_drain%0d: got %h/%b want %h/1", i, tx_data, tx_valid, exp_bytes[i]);
            else passed++;
            step();
        end
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) $display("FAIL fullpop_empty: got %b want 0", tx_valid); else passed++;
    endtask

    task automatic test_leds();
        address_dmem = A_LEDS;
        data         = 32'h1234_ABCD;
        wren         = 1'b1;
        step();
        wren = 1'b0;
        total++; if (leds !== 16'hABCD) $display("FAIL leds_out: got %h want ABCD", leds); else passed++;
        step();
        total++; if (q_dmem !== 32'h0000_ABCD) $display("FAIL leds_read: got %h want %h", q_dmem, 32'h0000_ABCD); else passed++;
    endtask

    task automatic test_errors();
        address_dmem = 32'h0001_0000;
        step();
        total++; if (q_dmem !== 32'h0) $display("FAIL unmapped_read: got %h want 0", q_dmem); else passed++;
        total++; if (bus_error !== 1'b1) $display("FAIL unmapped_err: got %b want 1", bus_error); else passed++;
        address_dmem = A_STATUS;
        step();
        total++; if (q_dmem !== 32'h06) $display("FAIL err_status_set: got %h want %h", q_dmem, 32'h06); else passed++;
        step();
        total++; if (q_dmem !== 32'h02) $display("FAIL err_status_clr: got %h want %h", q_dmem, 32'h02); else passed++;
        total++; if (bus_error !== 1'b0) $display("FAIL err_buserr_clr: got %b want 0", bus_error); else passed++;
        // Undefined MMIO offset: write ignored, reads 0, sets ERR
        address_dmem = 32'hFFFF_0004;
        data         = 32'hFFFF_FFFF;
        wren         = 1'b1;
        step();
        wren = 1'b0;
        total++; if (q_dmem !== 32'h0 || bus_error !== 1'b1)
            $display("FAIL bad_offset: got %h/%b want 0/1", q_dmem, bus_error); else passed++;
        address_dmem = A_STATUS;
        step();
        step();
        total++; if (bus_error !== 1'b0) $display("FAIL bad_offset_clr: got %b want 0", bus_error); else passed++;
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        push_byte(8'hA3);
        total++; if (tx_valid !== 1'b1) $display("FAIL mid_queued: got %b want 1", tx_valid); else passed++;
        reset        = 1'b1;
        address_dmem = 32'h0;
        step();
        reset = 1'b0;
        total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL mid_fifo: got %h/%b want 00/0", tx_data, tx_valid); else passed++;
        total++; if (leds !== 16'h0) $display("FAIL mid_leds: got %h want 0000", leds); else passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        reset        = 1'b1;
        address_dmem = 32'h0;
        data         = 32'h0;
        wren         = 1'b0;
        tx_ready     = 1'b0;
        #2;
        test_reset();
        test_counter();
        test_ram();
        test_fifo_basic();
        test_overflow();
        test_full_push_pop();
        test_leds();
        test_errors();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Target-side responder for the processor's data-memory port (address_dmem/data/wren in, q_dmem out).
- Word-addressed RAM backing store plus a small memory-mapped I/O window:
  - free-running cycle counter
  - byte-wide transmit FIFO with valid/ready output handshake
  - LED register
  - sticky error/status register
- Instantiated in the wrapper beside the regfile and imem, in place of a bare dmem RAM.

Parameters:
- DEPTH, 4096, RAM depth in 32-bit words (power of two).
- ADDR_W, 12, log2(DEPTH); RAM index = address_dmem[ADDR_W-1:0].
- FIFO_DEPTH, 8, transmit FIFO entries (power of two, >=2).
- MMIO_BASE, 16'hFFFF, address_dmem[31:16] value selecting the MMIO window.

Ports:
- clock  in  1  block clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address_dmem  in  32  word address from processor.
- data  in  32  write data from processor.
- wren  in  1  write enable from processor.
- q_dmem  out  32  registered read data.
- tx_data  out  8  head-of-FIFO byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts tx_data this cycle.
- leds  out  16  LED register contents.
- bus_error  out  1  mirror of status sticky error bit.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Wrapper drives clock with the inverted processor clock, so q_dmem is valid before the processor's next rising edge.
- Reset values:
  - q_dmem=0, cycle counter=0, leds=0.
  - FIFO empty: tx_valid=0, tx_data=0.
  - Sticky bits=0, bus_error=0.
  - RAM contents are not reset.
- Address decode, evaluated every cycle:
  - MMIO if address_dmem[31:16]==MMIO_BASE.
  - RAM if address_dmem < DEPTH.
  - Otherwise unmapped.
- Read latency: 1 clock. q_dmem reflects the address sampled at the previous edge and always updates; there is no read enable.
- RAM write: on wren, RAM[addr] <= data. Read-during-write to the same address returns the old word.
- Unmapped access:
  - Read returns 0.
  - Write is ignored.
  - Either access sets sticky ERR.
- MMIO offsets (address_dmem[7:0]); other offsets read 0, writes ignored, set ERR:
  - 0x00 CYCLE:
    - Read returns the current count.
    - Write loads data; the counter does not increment that cycle.
    - Otherwise the counter increments every clock and wraps 0xFFFFFFFF->0.
  - 0x01 TX_DATA:
    - Write pushes data[7:0].
    - Read returns 0.
  - 0x02 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 ERR, bit3 OVF.
    - bits[7:4] count (zero-extended, saturating display at 15).
    - Other bits 0.
    - A read returns the pre-edge snapshot and clears ERR and OVF at that edge.
    - If a new error or overflow occurs in the same cycle, set wins over clear.
  - 0x03 LEDS: read/write, 16 bits; reads are zero-extended.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - count range 0..FIFO_DEPTH.
  - Pop when tx_valid && tx_ready.
  - tx_data = head entry, combinationally from storage; 0 when empty.
- Push when full:
  - With a pop in the same cycle: push is accepted and count is unchanged.
  - Without a pop: byte is dropped and OVF is set.
- Push and pop together when empty: push only. The byte is not bypassed; tx_valid rises the next cycle.
- tx_ready is ignored when empty.
- tx_valid must remain high with tx_data stable until popped (AXI-style).
- Reset mid-transfer empties the FIFO immediately at that edge; any pending byte is lost.
- bus_error = ERR register.

Decomposition:
- Shared package dmem_map_pkg:
  - MMIO_BASE and offset constants OFF_CYCLE, OFF_TXDATA, OFF_STATUS, OFF_LEDS.
  - STATUS bit-index constants.
- Sub-module tx_fifo (parameter FIFO_DEPTH):
  - Ports: push, push_data[7:0], pop, head[7:0], full, empty, count.
  - Also implements the full+pop push rule.
- RAM array, decode, counter and status logic stay in dmem_responder.

Test Plan:
- Write 0xDEADBEEF to addr 5, then read addr 5 -> q_dmem=0xDEADBEEF one clock after the read address is presented; read addr 6 (never written after init-to-0 preload) -> 0.
- After reset, run 10 clocks, read 0xFFFF0000 -> value 10 (±defined sample edge); write 0xFFFFFFFE, read two cycles later -> wrapped to 0x00000000.
- Push 0x41,0x42,0x43 with tx_ready=0 -> STATUS=0x30 (count 3), tx_data=0x41; raise tx_ready for 3 clocks -> bytes 0x41,0x42,0x43 in order, then tx_valid=0, STATUS=0x02.
- Push 9 bytes with tx_ready=0 -> STATUS bit0=1, bit3=1, count 8; read STATUS again -> OVF cleared, full still 1.
- FIFO full, push 0x55 with tx_ready=1 same cycle -> count stays 8, 0x55 eventually emitted last.
- Read address 0x00010000 -> q_dmem=0, bus_error=1; read STATUS -> bit2=1; next STATUS read -> bit2=0, bus_error=0; assert reset with 3 bytes queued -> tx_valid=0, leds=0 next cycle.
